// File: rtl/pcie_vc_pkg.sv
// Shared definitions for the per-port virtual-channel ingress stage:
// VC index constants, flow-control state encoding and threshold width.
package pcie_vc_pkg;

    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

    localparam int UMBRAL_W = 4;

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } fc_state_e;

endpackage : pcie_vc_pkg

// File: rtl/vc_fifo.sv
// Single virtual-channel FIFO: owns its storage, read/write pointers and
// occupancy count. A push into a full FIFO is accepted only when a pop
// happens on the same edge; otherwise the word is silently discarded.
module vc_fifo
    import pcie_vc_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int BUS_SIZE   = 5,
    parameter int MEM_LENGTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [BUS_SIZE-1:0]   wr_data,
    output logic [BUS_SIZE-1:0]   rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [BUS_SIZE-1:0]   mem_r [MEM_LENGTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  pop_ok_s;
    logic                  push_ok_s;

    assign empty   = (count_r == {CNT_W{1'b0}});
    assign full    = (count_r == CNT_W'(MEM_LENGTH));
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Qualify push/pop: never pop an empty FIFO, and let a full FIFO take a
    // push only when a slot frees up on the same edge.
    always_comb begin
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
    end

    // Storage array; cleared on reset so a discarded burst leaves no data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_LENGTH; i++) begin
                mem_r[i] <= {BUS_SIZE{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap modulo the depth; the count tracks net push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r <= {ADDR_WIDTH{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule : vc_fifo

// File: rtl/vc_port_ingress.sv
// Per-port ingress stage: steers each incoming word by its MSB into one of
// two VC FIFOs, runs a RUN/PAUSED flow-control FSM per VC against the
// umbralA/umbralB thresholds, and drains both FIFOs through a single
// registered valid/ready output.
// Optional build macro: VC_RR_ARB_EN selects round-robin output arbitration
// between the VCs; when undefined VC0 has strict priority.
module vc_port_ingress
    import pcie_vc_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int BUS_SIZE   = 5,
    parameter int MEM_LENGTH = 1 << ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_SIZE:0]    data_in,
    input  logic                 valid_in,
    input  logic [UMBRAL_W-1:0]  umbralA,
    input  logic [UMBRAL_W-1:0]  umbralB,
    input  logic                 out_ready,
    output logic [BUS_SIZE-1:0]  out_data,
    output logic                 out_valid,
    output logic                 out_vc,
    output logic                 pause_vc0,
    output logic                 pause_vc1,
    output logic                 continue_vc0,
    output logic                 continue_vc1,
    output logic                 overflow
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int CMP_W = (CNT_W > UMBRAL_W) ? CNT_W : UMBRAL_W;

    logic [1:0]          push_s;
    logic [1:0]          pop_s;
    logic [1:0]          empty_s;
    logic [1:0]          full_s;
    logic [1:0]          accept_s;
    logic [1:0]          drop_s;
    logic [CNT_W-1:0]    count_s      [2];
    logic [CNT_W-1:0]    next_count_s [2];
    logic [BUS_SIZE-1:0] rd_data_s    [2];

    fc_state_e           fc_state_r   [2];
    fc_state_e           fc_next_s    [2];
    logic [1:0]          pause_r;
    logic [1:0]          continue_r;

    logic                load_s;
    logic                sel_valid_s;
    logic                sel_vc_s;
    logic [BUS_SIZE-1:0] sel_data_s;

    logic [BUS_SIZE-1:0] out_data_r;
    logic                out_valid_r;
    logic                out_vc_r;
    logic                overflow_r;

`ifdef VC_RR_ARB_EN
    logic                last_vc_r;
`endif

    // Flow-control transition rule; thresholds are zero-extended so the
    // compare is unsigned at a common width.
    function automatic fc_state_e fc_next(input fc_state_e        cur,
                                          input logic [CNT_W-1:0] nc,
                                          input logic [UMBRAL_W-1:0] thr_a,
                                          input logic [UMBRAL_W-1:0] thr_b);
        fc_state_e nxt;
        case (cur)
            RUN: begin
                if (CMP_W'(nc) >= CMP_W'(thr_a)) begin
                    nxt = PAUSED;
                end else begin
                    nxt = RUN;
                end
            end
            PAUSED: begin
                if (CMP_W'(nc) <= CMP_W'(thr_b)) begin
                    nxt = RUN;
                end else begin
                    nxt = PAUSED;
                end
            end
            default: nxt = RUN;
        endcase
        return nxt;
    endfunction

    // VC steering by the word MSB; there is no back-pressure on the input.
    always_comb begin
        push_s[0] = valid_in && (data_in[BUS_SIZE] == VC0);
        push_s[1] = valid_in && (data_in[BUS_SIZE] == VC1);
    end

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_vc
            vc_fifo #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .BUS_SIZE   (BUS_SIZE),
                .MEM_LENGTH (MEM_LENGTH)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .push    (push_s[g]),
                .pop     (pop_s[g]),
                .wr_data (data_in[BUS_SIZE-1:0]),
                .rd_data (rd_data_s[g]),
                .count   (count_s[g]),
                .empty   (empty_s[g]),
                .full    (full_s[g])
            );
        end
    endgenerate

    // Output arbiter: the register reloads whenever it is empty or being
    // consumed, popping the chosen VC head on that same edge.
    always_comb begin
        load_s      = !out_valid_r || out_ready;
        pop_s       = 2'b00;
        sel_valid_s = 1'b0;
        sel_vc_s    = VC0;
        if (load_s) begin
`ifdef VC_RR_ARB_EN
            if (!empty_s[0] && !empty_s[1]) begin
                sel_valid_s = 1'b1;
                if (last_vc_r == VC1) begin
                    sel_vc_s = VC0;
                end else begin
                    sel_vc_s = VC1;
                end
            end else if (!empty_s[0]) begin
                sel_valid_s = 1'b1;
                sel_vc_s    = VC0;
            end else if (!empty_s[1]) begin
                sel_valid_s = 1'b1;
                sel_vc_s    = VC1;
            end else begin
                sel_valid_s = 1'b0;
            end
`else
            if (!empty_s[0]) begin
                sel_valid_s = 1'b1;
                sel_vc_s    = VC0;
            end else if (!empty_s[1]) begin
                sel_valid_s = 1'b1;
                sel_vc_s    = VC1;
            end else begin
                sel_valid_s = 1'b0;
            end
`endif
            if (sel_valid_s) begin
                pop_s[sel_vc_s] = 1'b1;
            end else begin
                pop_s = 2'b00;
            end
        end else begin
            sel_valid_s = 1'b0;
        end
        sel_data_s = (sel_vc_s == VC1) ? rd_data_s[1] : rd_data_s[0];
    end

    // Per-VC accept/drop and the post-edge occupancy the FSMs look at.
    always_comb begin
        for (int v = 0; v < 2; v++) begin
            accept_s[v]     = push_s[v] && (!full_s[v] || pop_s[v]);
            drop_s[v]       = push_s[v] && full_s[v] && !pop_s[v];
            next_count_s[v] = count_s[v] + CNT_W'(accept_s[v]) - CNT_W'(pop_s[v]);
            fc_next_s[v]    = fc_next(fc_state_r[v], next_count_s[v], umbralA, umbralB);
        end
    end

    // Flow-control state registers plus registered pause level and the
    // single-cycle continue pulse on each PAUSED->RUN transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < 2; v++) begin
                fc_state_r[v] <= RUN;
            end
            pause_r    <= 2'b00;
            continue_r <= 2'b00;
        end else begin
            for (int v = 0; v < 2; v++) begin
                fc_state_r[v] <= fc_next_s[v];
                pause_r[v]    <= (fc_next_s[v] == PAUSED);
                continue_r[v] <= (fc_state_r[v] == PAUSED) && (fc_next_s[v] == RUN);
            end
        end
    end

`ifdef VC_RR_ARB_EN
    // Remembers the VC served last; starts at VC1 so VC0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_vc_r <= VC1;
        end else if (sel_valid_s) begin
            last_vc_r <= sel_vc_s;
        end else begin
            last_vc_r <= last_vc_r;
        end
    end
`endif

    // Output register: holds its word while stalled, reloads on load_s.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data_r  <= {BUS_SIZE{1'b0}};
            out_valid_r <= 1'b0;
            out_vc_r    <= 1'b0;
        end else if (load_s) begin
            if (sel_valid_s) begin
                out_data_r  <= sel_data_s;
                out_vc_r    <= sel_vc_s;
                out_valid_r <= 1'b1;
            end else begin
                out_data_r  <= out_data_r;
                out_vc_r    <= out_vc_r;
                out_valid_r <= 1'b0;
            end
        end else begin
            out_data_r  <= out_data_r;
            out_vc_r    <= out_vc_r;
            out_valid_r <= out_valid_r;
        end
    end

    // Sticky overflow flag: set by any dropped word, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | drop_s[0] | drop_s[1];
        end
    end

    assign out_data     = out_data_r;
    assign out_valid    = out_valid_r;
    assign out_vc       = out_vc_r;
    assign pause_vc0    = pause_r[0];
    assign pause_vc1    = pause_r[1];
    assign continue_vc0 = continue_r[0];
    assign continue_vc1 = continue_r[1];
    assign overflow     = overflow_r;

endmodule : vc_port_ingress

// File: tb/tb_vc_port_ingress.sv
// Self-checking bench for vc_port_ingress: table-driven latency/steering
// vectors, hand-written multi-cycle sequences, and a scoreboard queue that
// the output monitor pops on every out_valid/out_ready handshake.
module tb_vc_port_ingress;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] data_in = 6'b000000;
    logic       valid_in = 1'b0;
    logic [3:0] umbralA = 4'd6;
    logic [3:0] umbralB = 4'd3;
    logic       out_ready = 1'b0;
    logic [4:0] out_data;
    logic       out_valid;
    logic       out_vc;
    logic       pause_vc0;
    logic       pause_vc1;
    logic       continue_vc0;
    logic       continue_vc1;
    logic       overflow;

    typedef struct packed {
        logic       vc;
        logic [4:0] data;
    } exp_t;

    typedef struct {
        logic [5:0] din;
        logic [4:0] exp_data;
        logic       exp_vc;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[6];

    int checks = 0;
    int failures = 0;

    logic       hold_pend = 1'b0;
    logic [4:0] hold_data = 5'b00000;
    logic       hold_vc = 1'b0;

    vc_port_ingress #(
        .ADDR_WIDTH (3),
        .BUS_SIZE   (5),
        .MEM_LENGTH (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .umbralA      (umbralA),
        .umbralB      (umbralB),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_vc       (out_vc),
        .pause_vc0    (pause_vc0),
        .pause_vc1    (pause_vc1),
        .continue_vc0 (continue_vc0),
        .continue_vc1 (continue_vc1),
        .overflow     (overflow)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic vc, input logic [4:0] d);
        exp_t e;
        e.vc   = vc;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        valid_in = 1'b0;
        step();
        step();
        sb_q.delete();
        reset = 1'b1;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (sb_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d out_valid=%0d required pending=0 out_valid=0",
                     sb_q.size(), out_valid);
        end
    endtask

    // Output monitor: scoreboard compare on each handshake, stall stability.
    always @(negedge clk) begin
        if (!reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_data));
                check("hold_vc", 32'(out_vc), 32'(hold_vc));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual data=%0d vc=%0d required no word",
                             out_data, out_vc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_data", 32'(out_data), 32'(mon_e.data));
                    check("sb_vc", 32'(out_vc), 32'(mon_e.vc));
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            hold_vc   = out_vc;
        end
    end

    // Global time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        int pulses;
        int cont_cyc;
        logic prev_pause;

        vecs[0] = '{din: 6'b000000, exp_data: 5'b00000, exp_vc: 1'b0};
        vecs[1] = '{din: 6'b111111, exp_data: 5'b11111, exp_vc: 1'b1};
        vecs[2] = '{din: 6'b100000, exp_data: 5'b00000, exp_vc: 1'b1};
        vecs[3] = '{din: 6'b011111, exp_data: 5'b11111, exp_vc: 1'b0};
        vecs[4] = '{din: 6'b010101, exp_data: 5'b10101, exp_vc: 1'b0};
        vecs[5] = '{din: 6'b101010, exp_data: 5'b01010, exp_vc: 1'b1};

        // Reset held with valid_in high: everything stays zero, nothing written.
        reset = 1'b0;
        valid_in = 1'b1;
        data_in = 6'b011111;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_vc", 32'(out_vc), 32'd0);
        check("rst_pause_vc0", 32'(pause_vc0), 32'd0);
        check("rst_pause_vc1", 32'(pause_vc1), 32'd0);
        check("rst_cont_vc0", 32'(continue_vc0), 32'd0);
        check("rst_cont_vc1", 32'(continue_vc1), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        valid_in = 1'b0;
        step();
        step();
        check("rst_no_write", 32'(out_valid), 32'd0);

        // Table: single words into an idle stage, two-edge latency and steering.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = vecs[i].din;
            valid_in = 1'b1;
            sb_push(vecs[i].exp_vc, vecs[i].exp_data);
            step();
            valid_in = 1'b0;
            check("lat_pre", 32'(out_valid), 32'd0);
            step();
            check("lat_valid", 32'(out_valid), 32'd1);
            check("lat_data", 32'(out_data), 32'(vecs[i].exp_data));
            check("lat_vc", 32'(out_vc), 32'(vecs[i].exp_vc));
            step();
            check("lat_idle", 32'(out_valid), 32'd0);
        end

        // Pause threshold: a VC1 word occupies the output register, then six
        // VC0 words fill VC0 to the umbralA level.
        out_ready = 1'b0;
        data_in = 6'b100111;
        valid_in = 1'b1;
        sb_push(1'b1, 5'b00111);
        step();
        for (int i = 0; i < 6; i++) begin
            data_in = 6'b011011;
            sb_push(1'b0, 5'b11011);
            step();
            if (i == 4) check("pause_before", 32'(pause_vc0), 32'd0);
            if (i == 5) check("pause_rise", 32'(pause_vc0), 32'd1);
        end
        valid_in = 1'b0;
        check("pause_vc1_low", 32'(pause_vc1), 32'd0);
        check("cont_vc0_idle", 32'(continue_vc0), 32'd0);

        // Drain and resume: continue pulses once as VC0 count drops to 3.
        out_ready = 1'b1;
        pulses = 0;
        cont_cyc = -1;
        prev_pause = pause_vc0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (continue_vc0) begin
                pulses++;
                if (cont_cyc < 0) begin
                    cont_cyc = c;
                    check("cont_pause_fall", 32'(pause_vc0), 32'd0);
                    check("cont_prev_pause", 32'(prev_pause), 32'd1);
                end
            end
            prev_pause = pause_vc0;
        end
        check("cont_pulses", 32'(pulses), 32'd1);
        check("cont_cycle", 32'(cont_cyc), 32'd2);
        wait_drain();

        // Overflow: output register holds a VC0 word, nine VC1 words arrive,
        // the ninth is dropped.
        out_ready = 1'b0;
        data_in = 6'b010001;
        valid_in = 1'b1;
        sb_push(1'b0, 5'b10001);
        step();
        for (int i = 0; i < 9; i++) begin
            data_in = 6'b101101;
            if (i < 8) sb_push(1'b1, 5'b01101);
            step();
            if (i == 7) check("ovf_before", 32'(overflow), 32'd0);
            if (i == 8) check("ovf_set", 32'(overflow), 32'd1);
        end
        valid_in = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("ovf_sticky", 32'(overflow), 32'd1);
        out_ready = 1'b0;
        apply_reset();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Arbitration between two VC0 and two VC1 words.
        out_ready = 1'b0;
`ifdef VC_RR_ARB_EN
        sb_push(1'b0, 5'b00011);
        sb_push(1'b1, 5'b00101);
        sb_push(1'b0, 5'b11010);
        sb_push(1'b1, 5'b11001);
`else
        sb_push(1'b0, 5'b00011);
        sb_push(1'b0, 5'b11010);
        sb_push(1'b1, 5'b00101);
        sb_push(1'b1, 5'b11001);
`endif
        valid_in = 1'b1;
        data_in = 6'b000011;
        step();
        data_in = 6'b011010;
        step();
        data_in = 6'b100101;
        step();
        data_in = 6'b111001;
        step();
        valid_in = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Back-pressure: ready goes 1,0,1 while a word is presented.
        out_ready = 1'b0;
        valid_in = 1'b1;
        data_in = 6'b000001;
        sb_push(1'b0, 5'b00001);
        step();
        data_in = 6'b000010;
        sb_push(1'b0, 5'b00010);
        step();
        data_in = 6'b000011;
        sb_push(1'b0, 5'b00011);
        step();
        valid_in = 1'b0;
        check("bp_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        check("bp_held", 32'(out_data), 32'd2);
        out_ready = 1'b1;
        wait_drain();

        // umbralA=0 pauses on the first edge; with umbralB above it the exit
        // check fires on the next edge.
        out_ready = 1'b0;
        umbralA = 4'd0;
        apply_reset();
        check("ua0_rst_pause", 32'(pause_vc0), 32'd0);
        step();
        check("ua0_pause_vc0", 32'(pause_vc0), 32'd1);
        check("ua0_pause_vc1", 32'(pause_vc1), 32'd1);
        check("ua0_cont_low", 32'(continue_vc0), 32'd0);
        step();
        check("ua0_exit_pause", 32'(pause_vc0), 32'd0);
        check("ua0_exit_cont", 32'(continue_vc0), 32'd1);
        umbralA = 4'd6;
        apply_reset();

        // Mid-burst reset clears outputs without waiting for a clock edge.
        out_ready = 1'b0;
        valid_in = 1'b1;
        data_in = 6'b000111;
        for (int i = 0; i < 7; i++) begin
            step();
        end
        valid_in = 1'b0;
        check("mb_pause_pre", 32'(pause_vc0), 32'd1);
        check("mb_valid_pre", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mb_valid_async", 32'(out_valid), 32'd0);
        check("mb_pause_async", 32'(pause_vc0), 32'd0);
        check("mb_data_async", 32'(out_data), 32'd0);
        step();
        reset = 1'b1;
        step();
        step();
        check("mb_after_valid", 32'(out_valid), 32'd0);
        check("mb_after_pause", 32'(pause_vc0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vc_port_ingress

// File: doc/vc_port_ingress.md
Name: vc_port_ingress

Overview:
- Per-port ingress stage that directly consumes the data_pX/valid_pX stream produced by the stimulus generator.
- Steers each word by its MSB into one of two virtual-channel FIFOs (VC0/VC1) and raises pause/continue flow control against the umbralA/umbralB thresholds.
- Drains both FIFOs through a registered valid/ready output toward the switch crossbar.
- The top level instantiates one instance per port (P0, P1).

Parameters:
- ADDR_WIDTH, 3: FIFO address bits.
- BUS_SIZE, 5: payload width; input word is BUS_SIZE+1 bits.
- MEM_LENGTH, 1<<ADDR_WIDTH: FIFO depth per VC.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (reset==0 clears the block).
- data_in  in  BUS_SIZE+1  bit[BUS_SIZE] selects the VC (0=VC0, 1=VC1); bits[BUS_SIZE-1:0] are the payload.
- valid_in  in  1  data_in qualifier; no ready back-pressure, the upstream source relies on pause.
- umbralA  in  4  almost-full threshold.
- umbralB  in  4  almost-empty (resume) threshold.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  BUS_SIZE  payload at the FIFO head.
- out_valid  out  1  out_data valid.
- out_vc  out  1  VC of out_data.
- pause_vc0, pause_vc1  out  1  level: VC is in the PAUSED state.
- continue_vc0, continue_vc1  out  1  one-cycle pulse on the PAUSED->RUN transition.
- overflow  out  1  sticky; a word was dropped on a full FIFO.

Behaviour:
- Reset (asynchronous, reset==0): both FIFOs empty, pointers and counts 0. All outputs are 0: out_data, out_valid, out_vc, pause_*, continue_*, overflow. Both flow-control FSMs go to RUN. Reset asserted mid-transfer discards all contents immediately with no wait for a clock edge.
- Push:
  - On posedge, with valid_in=1 and the target FIFO not full: payload written, count+1.
  - With the target FIFO full (count==MEM_LENGTH): word dropped, count unchanged, overflow set to 1 until reset.
- Counts are ADDR_WIDTH+1 bits. Pointers are ADDR_WIDTH bits and wrap modulo MEM_LENGTH. Thresholds are zero-extended to count width before compare.
- Output stage:
  - Holds a single register. It loads when out_valid==0 or out_ready==1.
  - Load selection: VC0 head if VC0 is non-empty, else VC1 head, else out_valid drops to 0.
  - Latency: a word pushed into an empty FIFO with an idle output reaches out_valid on the 2nd posedge after the push edge (push edge, then load edge).
  - out_data and out_vc are stable while out_valid=1 and out_ready=0.
  - A pop and a push to the same VC on the same edge leave count unchanged. A pop from a full FIFO on the same edge as a push to it accepts the push with no drop.
- Flow-control FSM (per VC, states RUN and PAUSED), evaluated on next-count:
  - RUN -> PAUSED when next_count >= umbralA.
  - PAUSED -> RUN when next_count <= umbralB.
  - Otherwise the state holds.
  - If umbralA <= umbralB, PAUSED is still entered first; the exit check runs from the following cycle.
- pause_vcX is registered (equals state==PAUSED) and is visible the cycle after the crossing edge.
- continue_vcX is high for exactly one cycle, coincident with pause_vcX falling.
- umbralA=0 forces PAUSED from the first clock edge after reset release.

Optional Feature:
- Macro VC_RR_ARB_EN.
- Defined: output selection is round-robin between the VCs. A 1-bit last-served register (reset 1, so VC0 wins first) prefers the VC not served last when both are non-empty.
- Undefined: strict VC0 priority as described above. Ports and latency are identical in both builds.

Decomposition:
- Package pcie_vc_pkg holds:
  - VC index constants VC0=1'b0, VC1=1'b1.
  - Flow-control state encoding RUN=1'b0, PAUSED=1'b1.
  - Threshold width constant UMBRAL_W=4.
- Sub-module vc_fifo (parameters ADDR_WIDTH, BUS_SIZE) is instantiated twice. It provides push/pop, count, empty and full, and owns its memory and pointers.
- The top level holds the VC steering, the two flow-control FSMs, the arbiter and the output register.

Test Plan:
- Reset sequencing: reset=0 for 2 cycles with valid_in=1 -> all outputs 0 and no writes. Asserting reset=0 mid-burst clears out_valid and all pause_* asynchronously.
- Pause threshold: umbralA=6, umbralB=3, out_ready=0, 6 pushes of 6'b011011 -> pause_vc0 rises the cycle after the 6th push, pause_vc1 stays 0.
- Drain and resume: then out_ready=1 -> out_data=5'b11011 in order; continue_vc0 pulses for 1 cycle when the VC0 count reaches 3, and pause_vc0 falls in the same cycle.
- Overflow: out_ready=0, 9 pushes of 6'b101101 -> count saturates at 8, overflow=1 after the 9th push, and the drained data is exactly 8 words of 5'b01101.
- Arbitration: 2 pushes of VC0 (6'b000011, 6'b011010) and 2 of VC1 (6'b100101, 6'b111001) with out_ready=0, then out_ready=1:
  - Default build -> out_vc sequence 0,0,1,1.
  - VC_RR_ARB_EN build -> 0,1,0,1.
- Back-pressure: out_ready toggles 1,0,1 while out_valid=1 -> out_data is held during the 0 cycle, with no loss or duplication.
